// File: rtl/bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Start/ready handshake in, single-cycle done with bcd/overflow/digit_en out.

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_seq #(
  parameter int BIN_WIDTH = 13,
  parameter int DIGITS    = 4,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  overflow
);
  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int BW = 4*DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;

  logic [BIN_WIDTH-1:0]   bin_q;
  logic [DIGITS-1:0][3:0] dig_q, adj, dig_nx, res;
  logic [BW-1:0]          adj_flat;
  logic [CW-1:0]          cnt_q;
  logic [DIGITS-1:0]      en_nx;
  logic                   cout_q, cout_nx, ovf, acc, accept, last;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (.d(dig_q[k]), .q(adj[k]));
    end
  endgenerate

  // Corrected digits shift up one bit; the binary MSB enters digit 0.
  assign adj_flat = adj;
  assign dig_nx   = {adj_flat[BW-2:0], bin_q[BIN_WIDTH-1]};
  assign cout_nx  = cout_q | adj_flat[BW-1];
  assign accept   = (state == IDLE) && start;
  assign last     = (state == SHIFT) && (cnt_q == '0);
  assign ready    = (state == IDLE);

  // Final result: the top-digit range test is redundant but kept as a guard.
  assign ovf = cout_nx | (dig_nx[DIGITS-1] > 4'd9);
  assign res = (SATURATE && ovf) ? {DIGITS{4'h9}} : dig_nx;

  always_comb begin
    en_nx = '0;
    acc   = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      acc      = acc | (|res[i]);
      en_nx[i] = acc;
    end
    en_nx[0] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = SHIFT;
      SHIFT:   if (cnt_q == '0)  state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q    <= '0;
      dig_q    <= '0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      bcd      <= '0;
      digit_en <= DIGITS'(1);
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin_q  <= binary;
        dig_q  <= '0;
        cout_q <= 1'b0;
        cnt_q  <= CW'(BIN_WIDTH-1);
      end else if (state == SHIFT) begin
        bin_q  <= bin_q << 1;
        dig_q  <= dig_nx;
        cout_q <= cout_nx;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (last) begin
        bcd      <= res;
        digit_en <= en_nx;
        overflow <= ovf;
        done     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: four parameterisations share clk/rst_n/start/binary;
// a monitor checks every 13-bit conversion against an integer model.

module tb_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] binary;

  logic        r4, d4, o4;   logic [15:0] b4;  logic [3:0] e4;
  logic        r3s, d3s, o3s; logic [11:0] b3s; logic [2:0] e3s;
  logic        r3t, d3t, o3t; logic [11:0] b3t; logic [2:0] e3t;
  logic        r32, d32, o32; logic [39:0] b32; logic [9:0] e32;

  always #5 clk = ~clk;

  bcd_seq #(.BIN_WIDTH(13), .DIGITS(4), .SATURATE(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary[12:0]),
    .ready(r4), .done(d4), .bcd(b4), .digit_en(e4), .overflow(o4));
  bcd_seq #(.BIN_WIDTH(13), .DIGITS(3), .SATURATE(1'b1)) u3s (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary[12:0]),
    .ready(r3s), .done(d3s), .bcd(b3s), .digit_en(e3s), .overflow(o3s));
  bcd_seq #(.BIN_WIDTH(13), .DIGITS(3), .SATURATE(1'b0)) u3t (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary[12:0]),
    .ready(r3t), .done(d3t), .bcd(b3t), .digit_en(e3t), .overflow(o3t));
  bcd_seq #(.BIN_WIDTH(32), .DIGITS(10), .SATURATE(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .ready(r32), .done(d32), .bcd(b32), .digit_en(e32), .overflow(o32));

  int tests = 0, fails = 0, edge_cnt = 0, last_done = -1;
  bit hs_mode = 1'b0;

  typedef struct { logic [12:0] v; int acc; } pend_t;
  pend_t q[$];
  pend_t mp;
  logic [39:0] mb;
  logic [9:0]  me;
  logic        mo;

  typedef struct {
    logic [12:0] v;
    logic [15:0] b4;  logic [3:0] e4;
    logic [11:0] b3s; logic [2:0] e3s; logic o3;
    logic [11:0] b3t; logic [2:0] e3t;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Decimal reference via repeated division, independent of shift-and-add.
  function automatic void model(input longint v, input int nd, input bit sat,
                                output logic [39:0] b, output logic [9:0] en, output logic o);
    longint p = 1, t = v;
    repeat (nd) p = p * 10;
    o = (v >= p);
    b = '0;
    en = '0;
    for (int k = 0; k < nd; k++) begin
      b[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (o && sat) for (int k = 0; k < nd; k++) b[4*k +: 4] = 4'h9;
    for (int k = 0; k < nd; k++) begin
      en[k] = (k == 0);
      for (int j = k; j < nd; j++) if (b[4*j +: 4] != 4'h0) en[k] = 1'b1;
    end
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (d4) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_done: got done=1 required no pending conversion");
        end else begin
          mp = q.pop_front();
          chk("latency13", 64'(edge_cnt - mp.acc), 64'(13));
          chk("ready_in_done", 64'(r4), 64'(1));
          model(longint'(mp.v), 4, 1'b1, mb, me, mo);
          chk("m_bcd4", 64'(b4), 64'(mb[15:0]));
          chk("m_en4", 64'(e4), 64'(me[3:0]));
          chk("m_ovf4", 64'(o4), 64'(mo));
          model(longint'(mp.v), 3, 1'b1, mb, me, mo);
          chk("m_done3s", 64'(d3s), 64'(1));
          chk("m_bcd3s", 64'(b3s), 64'(mb[11:0]));
          chk("m_en3s", 64'(e3s), 64'(me[2:0]));
          chk("m_ovf3s", 64'(o3s), 64'(mo));
          model(longint'(mp.v), 3, 1'b0, mb, me, mo);
          chk("m_done3t", 64'(d3t), 64'(1));
          chk("m_bcd3t", 64'(b3t), 64'(mb[11:0]));
          chk("m_en3t", 64'(e3t), 64'(me[2:0]));
          chk("m_ovf3t", 64'(o3t), 64'(mo));
          if (hs_mode && last_done >= 0)
            chk("done_spacing", 64'(edge_cnt - last_done), 64'(14));
          last_done = edge_cnt;
        end
      end
      if (start && r4) q.push_back('{binary[12:0], edge_cnt + 1});
    end
  end

  task automatic conv(input logic [31:0] v);
    int n = 0;
    @(posedge clk); #2;
    while (!r4 && n < 60) begin @(posedge clk); #2; n++; end
    chk("ready_wait", 64'(r4), 64'(1));
    binary = v; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!d4 && n < 40);
    chk("conv_done", 64'(d4), 64'(1));
  endtask

  task automatic conv32(input logic [31:0] v, input logic [39:0] eb, input logic [9:0] ee);
    int n = 0, acc;
    @(posedge clk); #2;
    while (!(r32 && r4) && n < 80) begin @(posedge clk); #2; n++; end
    chk("ready32_wait", 64'(r32), 64'(1));
    binary = v; start = 1'b1;
    @(posedge clk); #2;
    acc = edge_cnt; start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!d32 && n < 50);
    chk("done32", 64'(d32), 64'(1));
    chk("latency32", 64'(edge_cnt - acc), 64'(32));
    chk("bcd32", 64'(b32), 64'(eb));
    chk("en32", 64'(e32), 64'(ee));
    chk("ovf32", 64'(o32), 64'(0));
  endtask

  initial begin
    int n, dcnt;
    tbl[0] = '{13'd8191, 16'h8191, 4'b1111, 12'h999, 3'b111, 1'b1, 12'h191, 3'b111};
    tbl[1] = '{13'd0,    16'h0000, 4'b0001, 12'h000, 3'b001, 1'b0, 12'h000, 3'b001};
    tbl[2] = '{13'd47,   16'h0047, 4'b0011, 12'h047, 3'b011, 1'b0, 12'h047, 3'b011};
    tbl[3] = '{13'd999,  16'h0999, 4'b0111, 12'h999, 3'b111, 1'b0, 12'h999, 3'b111};
    tbl[4] = '{13'd1000, 16'h1000, 4'b1111, 12'h999, 3'b111, 1'b1, 12'h000, 3'b001};
    tbl[5] = '{13'd1234, 16'h1234, 4'b1111, 12'h999, 3'b111, 1'b1, 12'h234, 3'b111};
    tbl[6] = '{13'd4096, 16'h4096, 4'b1111, 12'h999, 3'b111, 1'b1, 12'h096, 3'b011};
    tbl[7] = '{13'd100,  16'h0100, 4'b0111, 12'h100, 3'b111, 1'b0, 12'h100, 3'b111};
    tbl[8] = '{13'd5,    16'h0005, 4'b0001, 12'h005, 3'b001, 1'b0, 12'h005, 3'b001};
    tbl[9] = '{13'd6000, 16'h6000, 4'b1111, 12'h999, 3'b111, 1'b1, 12'h000, 3'b001};

    rst_n = 1'b0; start = 1'b0; binary = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(r4), 64'(1));
    chk("rst_done", 64'(d4), 64'(0));
    chk("rst_bcd", 64'(b4), 64'(0));
    chk("rst_en", 64'(e4), 64'(1));
    chk("rst_ovf", 64'(o4), 64'(0));
    chk("rst_en32", 64'(e32), 64'(1));
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      conv(32'(tbl[i].v));
      chk("t_bcd4", 64'(b4), 64'(tbl[i].b4));
      chk("t_en4", 64'(e4), 64'(tbl[i].e4));
      chk("t_ovf4", 64'(o4), 64'(0));
      chk("t_bcd3s", 64'(b3s), 64'(tbl[i].b3s));
      chk("t_en3s", 64'(e3s), 64'(tbl[i].e3s));
      chk("t_ovf3s", 64'(o3s), 64'(tbl[i].o3));
      chk("t_bcd3t", 64'(b3t), 64'(tbl[i].b3t));
      chk("t_en3t", 64'(e3t), 64'(tbl[i].e3t));
      chk("t_ovf3t", 64'(o3t), 64'(tbl[i].o3));
    end

    // start held high, binary changing every cycle across the full input range
    @(posedge clk); #2;
    hs_mode = 1'b1; last_done = -1; start = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      binary = 32'(i);
      @(posedge clk); #2;
    end
    start = 1'b0;
    n = 0;
    while (!r4 && n < 30) begin @(posedge clk); #2; n++; end
    chk("sweep_idle", 64'(r4), 64'(1));
    @(posedge clk); #2;
    hs_mode = 1'b0;

    // abort at the sixth shift edge
    binary = 32'd4321; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 64'(r4), 64'(1));
    chk("abort_done", 64'(d4), 64'(0));
    chk("abort_bcd", 64'(b4), 64'(0));
    chk("abort_en", 64'(e4), 64'(1));
    chk("abort_ovf", 64'(o4), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin @(negedge clk); if (d4) dcnt++; end
    chk("abort_no_done", 64'(dcnt), 64'(0));
    conv(32'd4321);
    chk("after_abort_bcd", 64'(b4), 64'(16'h4321));
    chk("after_abort_en", 64'(e4), 64'(4'b1111));

    conv32(32'hFFFF_FFFF, 40'h4294967295, 10'h3FF);
    conv32(32'd1000000000, 40'h1000000000, 10'h3FF);
    conv32(32'd0, 40'h0, 10'h001);

    repeat (20) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
